access_controller_p: RTL and testbench
======================================

ACCESS_CONTROLLER_P -- requirements
Module: access_controller_p

Interface
REQ-001 Parameter DIGITS, default 4, number of password digits per attempt (2..16).
REQ-002 Parameter DIGIT_W, default 4, width of one digit in bits.
REQ-003 Parameter LOAD_CH, default 2, number of gated load-button channels.
REQ-004 Parameter MAX_FAIL, default 3, consecutive failed attempts that trigger lockout (1..15).
REQ-005 Parameter LOCK_CYCLES, default 1000, lockout duration in clk cycles (>=2).
REQ-006 clk  input  1  sole clock; all state changes on posedge clk.
REQ-007 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-008 bt_check  input  1  digit-enter button, active-low, debounced upstream.
REQ-009 bt_relock  input  1  relock button, active-low, debounced upstream.
REQ-010 sw_check  input  DIGIT_W  digit value on switches.
REQ-011 rom_q  input  DIGIT_W  expected digit at addr_pt, valid one cycle after addr_pt changes.
REQ-012 bt_loadin  input  LOAD_CH  load buttons to be gated, active-low.
REQ-013 addr_pt  output  clog2(DIGITS)  password ROM address of the digit being entered.
REQ-014 bt_loadout  output  LOAD_CH  gated load buttons, active-low.
REQ-015 led_indicate  output  2  01 entry (red), 10 granted (green), 11 lockout.
REQ-016 fail_cnt  output  clog2(MAX_FAIL+1)  consecutive failed attempts.

Function
REQ-017 States SHALL be ENTRY, EVAL, GRANTED, LOCKOUT; all outputs registered.
REQ-018 A press SHALL be a bt_check 1->0 transition between consecutive clk samples; a held button counts once.
REQ-019 In ENTRY, each press SHALL compare sw_check with rom_q, set a sticky mismatch flag on inequality, and increment addr_pt in the same cycle.
REQ-020 The press for digit DIGITS-1 SHALL wrap addr_pt to 0 and move to EVAL.
REQ-021 EVAL SHALL last exactly one cycle: mismatch clear -> GRANTED with fail_cnt=0; mismatch set and fail_cnt+1<MAX_FAIL -> ENTRY with fail_cnt+1; otherwise -> LOCKOUT with fail_cnt=MAX_FAIL; mismatch cleared on exit.
REQ-022 In GRANTED, bt_loadout SHALL equal bt_loadin delayed one cycle; in every other state, bt_loadout SHALL be all ones.
REQ-023 LOCKOUT SHALL ignore bt_check, load LOCK_CYCLES into a down-counter on entry, and return to ENTRY with fail_cnt=0 and addr_pt=0 on the cycle the counter reaches 0.
REQ-024 Presses arriving in EVAL or LOCKOUT SHALL be discarded, not queued.
REQ-025 GRANTED SHALL ignore bt_check; exit only as per REQ-030 or reset.
REQ-026 led_indicate SHALL reflect the state registered in the same cycle (EVAL shows 01).

Reset
REQ-027 reset low SHALL immediately force ENTRY, addr_pt=0, fail_cnt=0, mismatch=0, led_indicate=01, bt_loadout all ones, lockout counter 0, press-detect register 1.
REQ-028 Reset mid-entry, in GRANTED, or in LOCKOUT SHALL discard all progress; first press after release is digit 0.
REQ-029 A bt_check held low through reset release SHALL NOT count as a press.

Configuration
REQ-030 With ACCESS_RELOCK_EN defined, a bt_relock 1->0 transition in GRANTED SHALL return to ENTRY, addr_pt=0, bt_loadout all ones next cycle; without it bt_relock is ignored and GRANTED is held until reset.

Verification
REQ-031 Defaults, ROM 5,7,4,5; enter 5,7,4,5 -> EVAL one cycle, then led_indicate=10, fail_cnt=0, bt_loadout follows bt_loadin with 1-cycle delay.
REQ-032 Enter 5,7,3,5 -> addr_pt 0 after 4th press, led_indicate=01, fail_cnt=1, bt_loadout=11.
REQ-033 Three wrong attempts -> led_indicate=11 for exactly 1000 cycles, presses ignored, then 01 with fail_cnt=0.
REQ-034 Hold bt_check low 50 cycles -> addr_pt advances by exactly 1.
REQ-035 Assert reset after 2 correct digits -> addr_pt=0 asynchronously; full correct sequence afterwards grants.
REQ-036 With ACCESS_RELOCK_EN, granted then bt_relock press -> led_indicate=01, bt_loadout=11; without it, no change.

Source files
------------

// File: rtl/access_controller_p.sv
// Keypad access controller: digit-by-digit password check against an external ROM,
// load-button gating while granted, lockout after repeated failures. Optional relock via ACCESS_RELOCK_EN.
module access_controller_p #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int LOAD_CH     = 2,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000,
    localparam int AW = $clog2(DIGITS),
    localparam int FW = $clog2(MAX_FAIL + 1),
    localparam int LW = $clog2(LOCK_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bt_check,
    input  logic               bt_relock,
    input  logic [DIGIT_W-1:0] sw_check,
    input  logic [DIGIT_W-1:0] rom_q,
    input  logic [LOAD_CH-1:0] bt_loadin,
    output logic [AW-1:0]      addr_pt,
    output logic [LOAD_CH-1:0] bt_loadout,
    output logic [1:0]         led_indicate,
    output logic [FW-1:0]      fail_cnt,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_EVAL    = 2'd1,
        ST_GRANTED = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DIGITS - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [FW-1:0] FAIL_ONE  = FW'(1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [LW-1:0] LOCK_INIT = LW'(LOCK_CYCLES);
    localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_d;
    logic [FW-1:0]      fail_d;
    logic               mismatch_q, mismatch_d;
    logic [LW-1:0]      lock_q, lock_d;
    logic [LOAD_CH-1:0] load_d;
    logic               check_q;
    logic               armed_q;
    logic               check_press;

    // armed_q keeps a button already held low at reset release from looking like a press
    assign check_press = armed_q & check_q & ~bt_check;

`ifdef ACCESS_RELOCK_EN
    logic relock_q;
    logic relock_press;
    assign relock_press = armed_q & relock_q & ~bt_relock;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) relock_q <= 1'b1;
        else        relock_q <= bt_relock;
    end
`else
    logic relock_unused;
    assign relock_unused = bt_relock;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ENTRY;
            addr_pt    <= '0;
            fail_cnt   <= '0;
            mismatch_q <= 1'b0;
            lock_q     <= '0;
            check_q    <= 1'b1;
            armed_q    <= 1'b0;
            bt_loadout <= '1;
        end else begin
            state_q    <= state_d;
            addr_pt    <= addr_d;
            fail_cnt   <= fail_d;
            mismatch_q <= mismatch_d;
            lock_q     <= lock_d;
            check_q    <= bt_check;
            armed_q    <= 1'b1;
            bt_loadout <= load_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_pt;
        fail_d     = fail_cnt;
        mismatch_d = mismatch_q;
        lock_d     = lock_q;
        case (state_q)
            ST_ENTRY: begin
                if (check_press) begin
                    mismatch_d = mismatch_q | (sw_check != rom_q);
                    if (addr_pt == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = ST_EVAL;
                    end else begin
                        addr_d = addr_pt + ADDR_ONE;
                    end
                end
            end
            ST_EVAL: begin
                mismatch_d = 1'b0;
                if (!mismatch_q) begin
                    state_d = ST_GRANTED;
                    fail_d  = '0;
                end else if (fail_cnt < FAIL_LAST) begin
                    state_d = ST_ENTRY;
                    fail_d  = fail_cnt + FAIL_ONE;
                end else begin
                    state_d = ST_LOCKOUT;
                    fail_d  = FAIL_MAX;
                    lock_d  = LOCK_INIT;
                end
            end
            ST_GRANTED: begin
`ifdef ACCESS_RELOCK_EN
                if (relock_press) begin
                    state_d = ST_ENTRY;
                    addr_d  = '0;
                end
`endif
            end
            ST_LOCKOUT: begin
                // counter is loaded on entry, so LOCK_CYCLES cycles are spent here
                lock_d = (lock_q == '0) ? '0 : lock_q - LOCK_ONE;
                if (lock_q <= LOCK_ONE) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                    addr_d  = '0;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_comb begin
        load_d = (state_d == ST_GRANTED) ? bt_loadin : '1;
        case (state_q)
            ST_GRANTED: led_indicate = 2'b10;
            ST_LOCKOUT: led_indicate = 2'b11;
            default:    led_indicate = 2'b01;
        endcase
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_access_controller_p.sv
// Directed bench for access_controller_p with default parameters and ROM contents 5,7,4,5.
module tb_access_controller_p;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bt_check = 1'b1;
    logic       bt_relock = 1'b1;
    logic [3:0] sw_check = 4'd0;
    logic [3:0] rom_q = 4'd0;
    logic [1:0] bt_loadin = 2'b11;
    logic [1:0] addr_pt;
    logic [1:0] bt_loadout;
    logic [1:0] led_indicate;
    logic [1:0] fail_cnt;
    logic [1:0] state_dbg;

    logic [3:0] rom [4];
    int n_checks = 0;
    int n_fail   = 0;

    access_controller_p dut (
        .clk(clk), .reset(reset), .bt_check(bt_check), .bt_relock(bt_relock),
        .sw_check(sw_check), .rom_q(rom_q), .bt_loadin(bt_loadin),
        .addr_pt(addr_pt), .bt_loadout(bt_loadout), .led_indicate(led_indicate),
        .fail_cnt(fail_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // synchronous ROM: data follows the address one cycle later
    always @(posedge clk) rom_q <= rom[addr_pt];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; bt_check = 1'b1; bt_relock = 1'b1; bt_loadin = 2'b11;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_digit(input logic [3:0] d);
        @(negedge clk);
        sw_check = d; bt_check = 1'b0;
        @(negedge clk);
        bt_check = 1'b1;
    endtask

    task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        press_digit(a); press_digit(b); press_digit(c); press_digit(d);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (led_indicate !== 2'b01) begin n_fail++; $display("FAIL reset_led: got %b expected 01", led_indicate); end
        n_checks++; if (addr_pt !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr_pt); end
        n_checks++; if (fail_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
        n_checks++; if (bt_loadout !== 2'b11) begin n_fail++; $display("FAIL reset_loadout: got %b expected 11", bt_loadout); end
        n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        do_reset();
    endtask

    task automatic test_grant();
        enter_code(4'd5, 4'd7, 4'd4, 4'd5);
        n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL grant_eval_state: got %0d expected 1", state_dbg); end
        n_checks++; if (led_indicate !== 2'b01) begin n_fail++; $display("FAIL grant_eval_led: got %b expected 01", led_indicate); end
        n_checks++; if (addr_pt !== 2'd0) begin n_fail++; $display("FAIL grant_eval_addr: got %0d expected 0", addr_pt); end
        bt_loadin = 2'b10;
        @(negedge clk);
        n_checks++; if (led_indicate !== 2'b10) begin n_fail++; $display("FAIL grant_led: got %b expected 10", led_indicate); end
        n_checks++; if (fail_cnt !== 2'd0) begin n_fail++; $display("FAIL grant_fail_cnt: got %0d expected 0", fail_cnt); end
        n_checks++; if (bt_loadout !== 2'b10) begin n_fail++; $display("FAIL grant_load_first: got %b expected 10", bt_loadout); end
        bt_loadin = 2'b01;
        #1;
        n_checks++; if (bt_loadout !== 2'b10) begin n_fail++; $display("FAIL grant_load_delay: got %b expected 10", bt_loadout); end
        @(negedge clk);
        n_checks++; if (bt_loadout !== 2'b01) begin n_fail++; $display("FAIL grant_load_follow: got %b expected 01", bt_loadout); end
        bt_loadin = 2'b11;
        press_digit(4'd5);
        repeat (2) @(negedge clk);
        n_checks++; if (led_indicate !== 2'b10) begin n_fail++; $display("FAIL grant_ignore_check: got %b expected 10", led_indicate); end
        bt_loadin = 2'b00;
        @(negedge clk);
        bt_relock = 1'b0;
        @(negedge clk);
        bt_relock = 1'b1;
`ifdef ACCESS_RELOCK_EN
        n_checks++; if (led_indicate !== 2'b01) begin n_fail++; $display("FAIL relock_led: got %b expected 01", led_indicate); end
        n_checks++; if (bt_loadout !== 2'b11) begin n_fail++; $display("FAIL relock_load: got %b expected 11", bt_loadout); end
`else
        n_checks++; if (led_indicate !== 2'b10) begin n_fail++; $display("FAIL relock_ignored_led: got %b expected 10", led_indicate); end
        n_checks++; if (bt_loadout !== 2'b00) begin n_fail++; $display("FAIL relock_ignored_load: got %b expected 00", bt_loadout); end
`endif
        do_reset();
    endtask

    task automatic test_wrong();
        enter_code(4'd5, 4'd7, 4'd3, 4'd5);
        n_checks++; if (addr_pt !== 2'd0) begin n_fail++; $display("FAIL wrong_addr: got %0d expected 0", addr_pt); end
        @(negedge clk);
        n_checks++; if (led_indicate !== 2'b01) begin n_fail++; $display("FAIL wrong_led: got %b expected 01", led_indicate); end
        n_checks++; if (fail_cnt !== 2'd1) begin n_fail++; $display("FAIL wrong_fail_cnt: got %0d expected 1", fail_cnt); end
        n_checks++; if (bt_loadout !== 2'b11) begin n_fail++; $display("FAIL wrong_loadout: got %b expected 11", bt_loadout); end
    endtask

    task automatic test_lockout();
        int lock_len;
        enter_code(4'd0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        n_checks++; if (fail_cnt !== 2'd2) begin n_fail++; $display("FAIL lock_second_fail: got %0d expected 2", fail_cnt); end
        enter_code(4'd1, 4'd1, 4'd1, 4'd1);
        @(negedge clk);
        n_checks++; if (led_indicate !== 2'b11) begin n_fail++; $display("FAIL lock_led: got %b expected 11", led_indicate); end
        n_checks++; if (fail_cnt !== 2'd3) begin n_fail++; $display("FAIL lock_fail_cnt: got %0d expected 3", fail_cnt); end
        lock_len = 0;
        for (int i = 0; i < 1100; i++) begin
            if (led_indicate !== 2'b11) break;
            lock_len++;
            bt_check = (i % 4 == 1) ? 1'b0 : 1'b1;
            sw_check = 4'd5;
            @(negedge clk);
        end
        bt_check = 1'b1;
        n_checks++; if (lock_len != 1000) begin n_fail++; $display("FAIL lock_length: got %0d expected 1000", lock_len); end
        n_checks++; if (led_indicate !== 2'b01) begin n_fail++; $display("FAIL lock_exit_led: got %b expected 01", led_indicate); end
        n_checks++; if (fail_cnt !== 2'd0) begin n_fail++; $display("FAIL lock_exit_fail_cnt: got %0d expected 0", fail_cnt); end
        n_checks++; if (addr_pt !== 2'd0) begin n_fail++; $display("FAIL lock_exit_addr: got %0d expected 0", addr_pt); end
    endtask

    task automatic test_hold();
        do_reset();
        @(negedge clk);
        bt_check = 1'b0; sw_check = 4'd5;
        repeat (50) @(negedge clk);
        n_checks++; if (addr_pt !== 2'd1) begin n_fail++; $display("FAIL hold_addr: got %0d expected 1", addr_pt); end
        bt_check = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        press_digit(4'd5); press_digit(4'd7);
        n_checks++; if (addr_pt !== 2'd2) begin n_fail++; $display("FAIL mid_addr_before: got %0d expected 2", addr_pt); end
        #2;
        reset = 1'b0; bt_check = 1'b0;
        #1;
        n_checks++; if (addr_pt !== 2'd0) begin n_fail++; $display("FAIL mid_async_addr: got %0d expected 0", addr_pt); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (addr_pt !== 2'd0) begin n_fail++; $display("FAIL held_through_reset: got %0d expected 0", addr_pt); end
        bt_check = 1'b1;
        @(negedge clk);
        enter_code(4'd5, 4'd7, 4'd4, 4'd5);
        @(negedge clk);
        n_checks++; if (led_indicate !== 2'b10) begin n_fail++; $display("FAIL mid_regrant_led: got %b expected 10", led_indicate); end
    endtask

    initial begin
        rom[0] = 4'd5; rom[1] = 4'd7; rom[2] = 4'd4; rom[3] = 4'd5;
        test_reset();
        test_grant();
        test_wrong();
        test_lockout();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
